// File: rtl/minute_counter.sv
// Time-of-day source for the display path: 1 s prescaler, seconds 0..59 and a
// wrapping minute count, with a pushbutton SET mode and a parallel preset load.
module minute_counter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int MODULUS = 512,
  parameter int COUNT_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               key_set,
  input  logic               key_inc,
  input  logic               key_dec,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_val,
  output logic [COUNT_W-1:0] minutes,
  output logic [5:0]         seconds,
  output logic               sec_tick,
  output logic               setting,
  output logic               colon
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0]      PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]      PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [COUNT_W-1:0] MIN_MAX  = COUNT_W'(MODULUS - 1);
  localparam int K_SET = 2;
  localparam int K_INC = 1;
  localparam int K_DEC = 0;

  typedef enum logic {ST_RUN, ST_SET} state_t;

  state_t             state;
  logic [PW-1:0]      presc;
  logic [PW-1:0]      presc_inc;
  logic [COUNT_W-1:0] min_up;
  logic [COUNT_W-1:0] min_dn;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         hist;
  logic [2:0]         press;

  assign presc_inc = presc + 1'b1;
  assign min_up    = (minutes == MIN_MAX) ? '0 : minutes + 1'b1;
  assign min_dn    = (minutes == '0) ? MIN_MAX : minutes - 1'b1;

  // Buttons are asynchronous: two flops to resynchronise, then a registered
  // one-shot so a held button produces exactly one press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      press <= '0;
    end else begin
      sync1 <= {key_set, key_inc, key_dec};
      sync2 <= sync1;
      hist  <= sync2;
      press <= sync2 & ~hist;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      presc    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      sec_tick <= 1'b0;
      setting  <= 1'b0;
      colon    <= 1'b1;
    end else begin
      sec_tick <= 1'b0;
      if (load) begin
        minutes <= (load_val > MIN_MAX) ? MIN_MAX : load_val;
        seconds <= '0;
        presc   <= '0;
        colon   <= 1'b1;
      end else if (press[K_SET]) begin
        state   <= (state == ST_RUN) ? ST_SET : ST_RUN;
        setting <= (state == ST_RUN);
        seconds <= '0;
        presc   <= '0;
        colon   <= 1'b1;
      end else if (state == ST_SET) begin
        seconds <= '0;
        presc   <= '0;
        colon   <= 1'b1;
        // Opposing presses landing together cancel out.
        if (press[K_INC] && !press[K_DEC]) begin
          minutes <= min_up;
        end else if (press[K_DEC] && !press[K_INC]) begin
          minutes <= min_dn;
        end
      end else if (run_en) begin
        if (presc == PRE_MAX) begin
          presc    <= '0;
          colon    <= 1'b1;
          sec_tick <= 1'b1;
          if (seconds == 6'd59) begin
            seconds <= '0;
            minutes <= min_up;
          end else begin
            seconds <= seconds + 6'd1;
          end
        end else begin
          presc <= presc_inc;
          colon <= (presc_inc < PRE_HALF);
        end
      end
    end
  end

endmodule

// File: tb/tb_minute_counter.sv
// Randomised and directed bench for minute_counter, checked against a
// cycle-level behavioural model of the clock/seconds/minutes rules.
module tb_minute_counter;

  localparam int CLK_HZ  = 4;
  localparam int MODULUS = 512;
  localparam int COUNT_W = 10;

  logic               clk;
  logic               rst_n;
  logic               run_en;
  logic               key_set;
  logic               key_inc;
  logic               key_dec;
  logic               load;
  logic [COUNT_W-1:0] load_val;
  logic [COUNT_W-1:0] minutes;
  logic [5:0]         seconds;
  logic               sec_tick;
  logic               setting;
  logic               colon;
  logic [18:0]        dut_vec;

  int tests  = 0;
  int errors = 0;

  // Behavioural model state: minutes, seconds, clocks elapsed in the second.
  int  m_min;
  int  m_sec;
  int  m_phase;
  int  cyc;
  bit  m_tick;
  bit  m_set;
  bit  p_set;
  bit  p_inc;
  bit  p_dec;
  int  set_q[$];
  int  inc_q[$];
  int  dec_q[$];

  minute_counter #(
    .CLK_HZ (CLK_HZ),
    .MODULUS(MODULUS),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_en  (run_en),
    .key_set (key_set),
    .key_inc (key_inc),
    .key_dec (key_dec),
    .load    (load),
    .load_val(load_val),
    .minutes (minutes),
    .seconds (seconds),
    .sec_tick(sec_tick),
    .setting (setting),
    .colon   (colon)
  );

  assign dut_vec = {minutes, seconds, sec_tick, setting, colon};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] exp_vec();
    bit c;
    c = m_set ? 1'b1 : (m_phase < CLK_HZ / 2);
    return {10'(m_min), 6'(m_sec), m_tick, m_set, c};
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_phase = 0; cyc = 0;
    m_tick = 0; m_set = 0;
    p_set = 0; p_inc = 0; p_dec = 0;
    set_q.delete(); inc_q.delete(); dec_q.delete();
  endtask

  // One clock: advance the model at the rising edge, return at the falling edge.
  task automatic step();
    bit ev_set, ev_inc, ev_dec;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      cyc++;
      // A button rising before this edge acts on the 4th edge after the rise.
      if (key_set && !p_set) set_q.push_back(cyc + 3);
      if (key_inc && !p_inc) inc_q.push_back(cyc + 3);
      if (key_dec && !p_dec) dec_q.push_back(cyc + 3);
      p_set = key_set; p_inc = key_inc; p_dec = key_dec;
      ev_set = (set_q.size() > 0) && (set_q[0] == cyc);
      ev_inc = (inc_q.size() > 0) && (inc_q[0] == cyc);
      ev_dec = (dec_q.size() > 0) && (dec_q[0] == cyc);
      if (ev_set) void'(set_q.pop_front());
      if (ev_inc) void'(inc_q.pop_front());
      if (ev_dec) void'(dec_q.pop_front());
      m_tick = 0;
      if (load) begin
        m_min = (int'(load_val) > MODULUS - 1) ? MODULUS - 1 : int'(load_val);
        m_sec = 0; m_phase = 0;
      end else if (ev_set) begin
        m_set = !m_set; m_sec = 0; m_phase = 0;
      end else if (m_set) begin
        m_sec = 0; m_phase = 0;
        if (ev_inc && !ev_dec) m_min = (m_min + 1) % MODULUS;
        else if (ev_dec && !ev_inc) m_min = (m_min + MODULUS - 1) % MODULUS;
      end else if (run_en) begin
        m_phase++;
        if (m_phase == CLK_HZ) begin
          m_phase = 0; m_tick = 1; m_sec++;
          if (m_sec == 60) begin
            m_sec = 0; m_min = (m_min + 1) % MODULUS;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic press_key(input int which);
    if (which == 2) key_set = 1'b1; else if (which == 1) key_inc = 1'b1; else key_dec = 1'b1;
    repeat (3) step();
    key_set = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; run_en = 1'b0; key_set = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    load = 1'b0; load_val = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (dut_vec !== 19'h1) begin
      errors++;
      $display("[TB] FAIL reset_state got=%h exp=%h", dut_vec, 19'h1);
    end
    repeat (3) begin
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL reset_hold got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    int ticks = 0;
    run_en = 1'b1;
    repeat (240) begin
      step();
      if (sec_tick === 1'b1) ticks++;
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    tests++;
    if (ticks != 60 || minutes !== 10'd1 || seconds !== 6'd0) begin
      errors++;
      $display("[TB] FAIL run_minute ticks=%0d min=%0d sec=%0d exp ticks=60 min=1 sec=0",
               ticks, minutes, seconds);
    end
  endtask

  task automatic test_load_wrap();
    load = 1'b1; load_val = 10'd511;
    step();
    load = 1'b0;
    tests++;
    if (minutes !== 10'd511 || seconds !== 6'd0) begin
      errors++;
      $display("[TB] FAIL load_511 got min=%0d sec=%0d exp min=511 sec=0", minutes, seconds);
    end
    repeat (240) begin
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL load_run cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    tests++;
    if (minutes !== 10'd0 || seconds !== 6'd0) begin
      errors++;
      $display("[TB] FAIL minute_wrap got min=%0d sec=%0d exp min=0 sec=0", minutes, seconds);
    end
  endtask

  task automatic test_set_mode();
    key_set = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3) key_set = 1'b0;
      tests++;
      if (setting !== ((i >= 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL set_latency edge=%0d got=%b exp=%b", i, setting, (i >= 4));
      end
    end
    repeat (3) begin
      press_key(1);
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL inc got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    tests++;
    if (minutes !== 10'd3) begin
      errors++;
      $display("[TB] FAIL inc_x3 got=%0d exp=3", minutes);
    end
    repeat (4) begin
      press_key(0);
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL dec got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    tests++;
    if (minutes !== 10'd511 || setting !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dec_wrap got min=%0d set=%b exp min=511 set=1", minutes, setting);
    end
  endtask

  task automatic test_simultaneous();
    key_inc = 1'b1; key_dec = 1'b1;
    repeat (3) step();
    key_inc = 1'b0; key_dec = 1'b0;
    repeat (3) step();
    tests++;
    if (minutes !== 10'd511 || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL inc_dec_cancel got=%h exp=%h", dut_vec, exp_vec());
    end
    load = 1'b1; load_val = 10'd600;
    step();
    load = 1'b0;
    tests++;
    if (minutes !== 10'd511 || setting !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_clamp got min=%0d set=%b exp min=511 set=1", minutes, setting);
    end
    // Set press whose effect edge lands on a load: the set press is lost.
    key_set = 1'b1;
    repeat (3) step();
    load = 1'b1; load_val = 10'd42;
    step();
    load = 1'b0; key_set = 1'b0;
    repeat (3) step();
    tests++;
    if (minutes !== 10'd42 || setting !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL load_beats_set got=%h exp min=42 set=1 model=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_exit_set();
    press_key(2);
    tests++;
    if (setting !== 1'b0 || seconds !== 6'd0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL exit_set got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pause();
    bit found = 0;
    bit held_ok = 1;
    int n = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_tick && m_sec == 30) found = 1;
    end
    tests++;
    if (!found || seconds !== 6'd30) begin
      errors++;
      $display("[TB] FAIL reach_30 got sec=%0d exp sec=30 (found=%0d)", seconds, found);
    end
    run_en = 1'b0;
    repeat (20) begin
      step();
      if (seconds !== 6'd30 || sec_tick !== 1'b0) held_ok = 0;
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL pause got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    tests++;
    if (!held_ok) begin
      errors++;
      $display("[TB] FAIL pause_hold got sec=%0d tick=%b exp sec=30 tick=0", seconds, sec_tick);
    end
    run_en = 1'b1;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      step();
      if (sec_tick === 1'b1) n = i;
    end
    tests++;
    if (n != 4 || seconds !== 6'd31) begin
      errors++;
      $display("[TB] FAIL resume_tick got cycles=%0d sec=%0d exp cycles=4 sec=31", n, seconds);
    end
  endtask

  task automatic test_random();
    logic [2:0] kv;
    int stab[3];
    kv = '0;
    for (int k = 0; k < 3; k++) stab[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run_en = ~run_en;
      load = ($urandom_range(0, 63) == 0);
      load_val = 10'($urandom_range(0, 1023));
      for (int k = 0; k < 3; k++) begin
        stab[k]++;
        if (stab[k] >= 3 && $urandom_range(0, (k == 2) ? 40 : 8) == 0) begin
          kv[k] = ~kv[k];
          stab[k] = 0;
        end
      end
      key_set = kv[2]; key_inc = kv[1]; key_dec = kv[0];
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    key_set = 1'b0; key_inc = 1'b0; key_dec = 1'b0; load = 1'b0; run_en = 1'b1;
    repeat (8) begin
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_drain got=%h exp=%h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    if (setting !== 1'b1) press_key(2);
    load = 1'b1; load_val = 10'd100;
    step();
    load = 1'b0;
    tests++;
    if (minutes !== 10'd100 || setting !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset got min=%0d set=%b exp min=100 set=1", minutes, setting);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (dut_vec !== 19'h1) begin
      errors++;
      $display("[TB] FAIL async_reset got=%h exp=%h", dut_vec, 19'h1);
    end
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) begin
      step();
      tests++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL post_reset got=%h exp=%h", dut_vec, exp_vec());
      end
    end
    tests++;
    if (setting !== 1'b0 || minutes !== 10'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_state got min=%0d set=%b exp min=0 set=0", minutes, setting);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_wrap();
    test_set_mode();
    test_simultaneous();
    test_exit_set();
    test_pause();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
